mem_port_arb: RTL and testbench

MEM_PORT_ARB -- requirements
Module: mem_port_arb

---
 rtl/mem_port_arb.sv | 143 ++++++++++++++
 tb/tb_mem_port_arb.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arb.sv
// Memory port arbiter: shares one memory bus between the table walker (W),
// the data cache (D) and the instruction cache (I). The walker always wins;
// D and I either alternate (RR_EN=1) or D wins outright (RR_EN=0).
//
// state | meaning
// IDLE  | no owner, bus outputs parked at 0
// GW    | table walker owns the bus
// GD    | data cache owns the bus
// GI    | instruction cache owns the bus
module mem_port_arb #(
  parameter bit RR_EN = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        WReq,
  input  logic        DReq,
  input  logic        IReq,
  input  logic        WWrite,
  input  logic        DWrite,
  input  logic        IWrite,
  input  logic [31:0] WAddr,
  input  logic [31:0] DAddr,
  input  logic [31:0] IAddr,
  input  logic [31:0] WWData,
  input  logic [31:0] DWData,
  input  logic [31:0] IWData,
  input  logic        Abort,
  input  logic        HReady,
  input  logic [31:0] HRData,
  output logic        HRequest,
  output logic        HWrite,
  output logic [31:0] HAddr,
  output logic [31:0] HWData,
  output logic        WReady,
  output logic        DReady,
  output logic        IReady,
  output logic [31:0] RData,
  output logic [1:0]  GrantState
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GW   = 2'd1,
    GD   = 2'd2,
    GI   = 2'd3
  } grant_t;

  grant_t state;
  grant_t winner;
  grant_t next_state;
  logic   last_is_i;   // 0: D held the bus last, 1: I held it last
  logic   owner_req;
  logic   beat_done;

  // Request of whoever currently owns the bus (0 in IDLE).
  always_comb begin
    owner_req = 1'b0;
    case (state)
      GW:      owner_req = WReq;
      GD:      owner_req = DReq;
      GI:      owner_req = IReq;
      default: owner_req = 1'b0;
    endcase
  end

  // Arbitration among current requests; W first, then D/I by policy.
  always_comb begin
    winner = IDLE;
    if (WReq)
      winner = GW;
    else if (DReq && IReq)
      winner = (RR_EN && !last_is_i) ? GI : GD;
    else if (DReq)
      winner = GD;
    else if (IReq)
      winner = GI;
  end

  // Abort wins over everything; otherwise hold while the owner still
  // requests, and re-arbitrate directly on release (no IDLE bubble).
  always_comb begin
    next_state = state;
    if (Abort)
      next_state = IDLE;
    else if (!owner_req)
      next_state = winner;
  end

  // Grant state and the D/I fairness flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      last_is_i <= 1'b0;
    end else begin
      state <= next_state;
      if (next_state == GD)
        last_is_i <= 1'b0;
      else if (next_state == GI)
        last_is_i <= 1'b1;
    end
  end

  // Bus mux from the owner; Abort suppresses the request in its own cycle.
  always_comb begin
    HRequest = 1'b0;
    HWrite   = 1'b0;
    HAddr    = 32'd0;
    HWData   = 32'd0;
    case (state)
      GW: begin
        HRequest = WReq & ~Abort;
        HWrite   = WWrite;
        HAddr    = WAddr;
        HWData   = WWData;
      end
      GD: begin
        HRequest = DReq & ~Abort;
        HWrite   = DWrite;
        HAddr    = DAddr;
        HWData   = DWData;
      end
      GI: begin
        HRequest = IReq & ~Abort;
        HWrite   = IWrite;
        HAddr    = IAddr;
        HWData   = IWData;
      end
      default: ;
    endcase
  end

  // Beat completion is routed only to the owner.
  always_comb begin
    beat_done = HReady & HRequest;
    WReady    = (state == GW) & beat_done;
    DReady    = (state == GD) & beat_done;
    IReady    = (state == GI) & beat_done;
  end

  assign RData      = HRData;
  assign GrantState = state;

endmodule

// File: tb/tb_mem_port_arb.sv
// Bench for mem_port_arb: a round-robin and a fixed-priority instance share
// the same stimulus and are compared every cycle against an owner-based
// reference model, followed by directed scenarios and a random phase.
module tb_mem_port_arb;

  logic clk = 1'b0;
  logic reset;
  logic WReq, DReq, IReq, WWrite, DWrite, IWrite, Abort, HReady;
  logic [31:0] WAddr, DAddr, IAddr, WWData, DWData, IWData, HRData;

  logic        hreq_r, hwr_r, wrdy_r, drdy_r, irdy_r;
  logic [31:0] haddr_r, hwd_r, rdata_r;
  logic [1:0]  gs_r;
  logic        hreq_f, hwr_f, wrdy_f, drdy_f, irdy_f;
  logic [31:0] haddr_f, hwd_f, rdata_f;
  logic [1:0]  gs_f;

  always #5 clk = ~clk;

  mem_port_arb #(.RR_EN(1'b1)) dut_r (
    .clk(clk), .reset(reset),
    .WReq(WReq), .DReq(DReq), .IReq(IReq),
    .WWrite(WWrite), .DWrite(DWrite), .IWrite(IWrite),
    .WAddr(WAddr), .DAddr(DAddr), .IAddr(IAddr),
    .WWData(WWData), .DWData(DWData), .IWData(IWData),
    .Abort(Abort), .HReady(HReady), .HRData(HRData),
    .HRequest(hreq_r), .HWrite(hwr_r), .HAddr(haddr_r), .HWData(hwd_r),
    .WReady(wrdy_r), .DReady(drdy_r), .IReady(irdy_r),
    .RData(rdata_r), .GrantState(gs_r)
  );

  mem_port_arb #(.RR_EN(1'b0)) dut_f (
    .clk(clk), .reset(reset),
    .WReq(WReq), .DReq(DReq), .IReq(IReq),
    .WWrite(WWrite), .DWrite(DWrite), .IWrite(IWrite),
    .WAddr(WAddr), .DAddr(DAddr), .IAddr(IAddr),
    .WWData(WWData), .DWData(DWData), .IWData(IWData),
    .Abort(Abort), .HReady(HReady), .HRData(HRData),
    .HRequest(hreq_f), .HWrite(hwr_f), .HAddr(haddr_f), .HWData(hwd_f),
    .WReady(wrdy_f), .DReady(drdy_f), .IReady(irdy_f),
    .RData(rdata_f), .GrantState(gs_f)
  );

  int checks = 0;
  int errors = 0;

  // Model: owner per instance (0 none, 1 W, 2 D, 3 I), last D/I owner,
  // and whether a beat is outstanding (owner may not drop its request).
  int ms[2];
  int mlast[2];
  bit pend[2];
  bit rr[2] = '{1'b1, 1'b0};
  string nm[9] = '{"grant_state", "hrequest", "hwrite", "haddr", "hwdata",
                   "rdata", "wready", "dready", "iready"};

  task automatic chk(string tag, logic [31:0] obs_v, logic [31:0] exp_v);
    checks++;
    assert (obs_v === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs_v, exp_v);
    end
  endtask

  function automatic bit oreq(int o);
    return (o == 1) ? WReq : (o == 2) ? DReq : (o == 3) ? IReq : 1'b0;
  endfunction

  function automatic int pick(int k);
    if (WReq) return 1;
    if (DReq && IReq) return (rr[k] && mlast[k] == 2) ? 3 : 2;
    if (DReq) return 2;
    if (IReq) return 3;
    return 0;
  endfunction

  function automatic logic [31:0] obs(int k, int i);
    case (i)
      0: return (k == 0) ? {30'd0, gs_r} : {30'd0, gs_f};
      1: return (k == 0) ? {31'd0, hreq_r} : {31'd0, hreq_f};
      2: return (k == 0) ? {31'd0, hwr_r} : {31'd0, hwr_f};
      3: return (k == 0) ? haddr_r : haddr_f;
      4: return (k == 0) ? hwd_r : hwd_f;
      5: return (k == 0) ? rdata_r : rdata_f;
      6: return (k == 0) ? {31'd0, wrdy_r} : {31'd0, wrdy_f};
      7: return (k == 0) ? {31'd0, drdy_r} : {31'd0, drdy_f};
      default: return (k == 0) ? {31'd0, irdy_r} : {31'd0, irdy_f};
    endcase
  endfunction

  // Called at a falling edge with inputs already applied: checks every
  // output of both instances, then advances the model across the next
  // rising edge and returns at the following falling edge.
  task automatic step();
    logic [31:0] ex[9];
    int o, n;
    bit r;
    if (reset) begin
      ms = '{0, 0}; mlast = '{2, 2}; pend = '{1'b0, 1'b0};
    end
    #1;
    for (int k = 0; k < 2; k++) begin
      o = ms[k];
      if (pend[k] && o != 0 && !oreq(o)) begin
        errors++;
        $error("FAIL req_drop_midbeat dut%0d owner=%0d observed=0 expected=1", k, o);
      end
      r = (o != 0) && oreq(o) && !Abort;
      ex[0] = o;
      ex[1] = {31'd0, r};
      ex[2] = (o == 1) ? {31'd0, WWrite} : (o == 2) ? {31'd0, DWrite} :
              (o == 3) ? {31'd0, IWrite} : 32'd0;
      ex[3] = (o == 1) ? WAddr : (o == 2) ? DAddr : (o == 3) ? IAddr : 32'd0;
      ex[4] = (o == 1) ? WWData : (o == 2) ? DWData : (o == 3) ? IWData : 32'd0;
      ex[5] = HRData;
      ex[6] = {31'd0, (o == 1) && r && HReady};
      ex[7] = {31'd0, (o == 2) && r && HReady};
      ex[8] = {31'd0, (o == 3) && r && HReady};
      for (int i = 0; i < 9; i++)
        chk($sformatf("%s_dut%0d", nm[i], k), obs(k, i), ex[i]);
      pend[k] = r && !HReady;
    end
    @(posedge clk);
    if (!reset) begin
      for (int k = 0; k < 2; k++) begin
        if (Abort) n = 0;
        else if (ms[k] != 0 && oreq(ms[k])) n = ms[k];
        else n = pick(k);
        if (n >= 2) mlast[k] = n;
        ms[k] = n;
      end
    end
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    WReq = 0; DReq = 0; IReq = 0; WWrite = 0; DWrite = 0; IWrite = 0;
    Abort = 0; HReady = 0; HRData = 0;
  endtask

  initial begin
    ms = '{0, 0}; mlast = '{2, 2}; pend = '{1'b0, 1'b0};
    reset = 1'b1;
    clear_inputs();
    WAddr = $urandom; DAddr = $urandom; IAddr = $urandom;
    WWData = $urandom; DWData = $urandom; IWData = $urandom;
    step();
    step();
    reset = 1'b0;

    // First D/I tie after reset goes to I; releases walk GI -> GD -> IDLE.
    DReq = 1; IReq = 1; HReady = 1; DWrite = 1;
    step();
    chk("tie_first_gi", {30'd0, gs_r}, 32'd3);
    chk("tie_fixed_gd", {30'd0, gs_f}, 32'd2);
    IReq = 0;
    step();
    chk("i_release_gd", {30'd0, gs_r}, 32'd2);
    DReq = 0;
    step();
    chk("d_release_idle", {30'd0, gs_r}, 32'd0);

    // Stalled beat in GD holds address and withholds DReady.
    DReq = 1; HReady = 0;
    step();
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("stall_haddr", haddr_r, DAddr);
      chk("stall_dready", {31'd0, drdy_r}, 32'd0);
      step();
    end
    HReady = 1;
    #1;
    chk("beat_dready", {31'd0, drdy_r}, 32'd1);
    step();
    DReq = 0;
    #1;
    chk("dready_one_cycle", {31'd0, drdy_r}, 32'd0);
    step();

    // W arriving during GI waits, then takes over directly on release.
    IReq = 1; IWrite = 1;
    step();
    WReq = 1;
    step();
    chk("w_no_preempt", {30'd0, gs_r}, 32'd3);
    step();
    chk("w_no_preempt2", {30'd0, gs_r}, 32'd3);
    IReq = 0;
    step();
    chk("w_direct_gw", {30'd0, gs_r}, 32'd1);
    WReq = 0;
    step();

    // Abort in GD: request suppressed, IDLE next, GD again after that.
    DReq = 1;
    step();
    Abort = 1;
    #1;
    chk("abort_hreq", {31'd0, hreq_r}, 32'd0);
    chk("abort_dready", {31'd0, drdy_r}, 32'd0);
    step();
    Abort = 0;
    chk("abort_idle", {30'd0, gs_r}, 32'd0);
    step();
    chk("abort_regrant", {30'd0, gs_r}, 32'd2);
    DReq = 0;
    step();

    // Fixed priority with D and I both held: I never gets the bus even
    // when D's tenure is cut every two beats.
    DReq = 1; IReq = 1; HReady = 1;
    for (int it = 0; it < 5; it++) begin
      for (int b = 0; b < 3; b++) begin
        step();
        chk("fixed_no_i", {31'd0, gs_f == 2'd3}, 32'd0);
      end
      Abort = 1;
      step();
      Abort = 0;
    end
    DReq = 0; IReq = 0;
    step();
    step();

    // Reset mid-beat in GW: immediate IDLE, outputs 0, no WReady.
    WReq = 1; HReady = 0; WWrite = 1;
    step();
    step();
    reset = 1'b1;
    #1;
    chk("rst_gs", {30'd0, gs_r}, 32'd0);
    chk("rst_hreq", {31'd0, hreq_r}, 32'd0);
    chk("rst_haddr", haddr_r, 32'd0);
    chk("rst_wready", {31'd0, wrdy_r}, 32'd0);
    step();
    clear_inputs();
    step();
    reset = 1'b0;
    step();

    // Random traffic, keeping any owner with an outstanding beat requesting.
    for (int cyc = 0; cyc < 400; cyc++) begin
      WReq = ($urandom_range(0, 3) == 0);
      DReq = $urandom_range(0, 1);
      IReq = $urandom_range(0, 1);
      WWrite = $urandom_range(0, 1);
      DWrite = $urandom_range(0, 1);
      IWrite = $urandom_range(0, 1);
      WAddr = $urandom; DAddr = $urandom; IAddr = $urandom;
      WWData = $urandom; DWData = $urandom; IWData = $urandom;
      HRData = $urandom;
      HReady = ($urandom_range(0, 9) < 7);
      Abort = ($urandom_range(0, 19) == 0);
      for (int k = 0; k < 2; k++) begin
        if (pend[k]) begin
          if (ms[k] == 1) WReq = 1;
          if (ms[k] == 2) DReq = 1;
          if (ms[k] == 3) IReq = 1;
        end
      end
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
